frame_burst_issuer: RTL and testbench
=====================================

Name: frame_burst_issuer

Overview:
- Read-side burst scheduler for the VDMA frame buffer. It walks one frame as lines × (full bursts + optional tail burst) and issues AXI-style read address requests.
- It drives the new_base, burst_done and tail_done strobes of the companion frame address generator. It consumes that generator's current address as the request address.
- Sits between the frame sync/control logic and the AXI AR channel master.

Parameters:
- ASIZE, 29, address width.
- LSIZE, 8, burst length field width (ar_len).
- BURST_LEN, 256, beats per full burst; 1..2^LSIZE.
- ADDR_SETTLE, 3, wait cycles after any strobe before the address generator output is used; ≥1.

Ports:
- clock  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle pulse; starts a frame when idle.
- line_bursts  in  16  full bursts per line; latched at frame_start.
- tail_len  in  LSIZE+1  tail burst beats, 0 = no tail; must be < BURST_LEN; latched at frame_start.
- vactive  in  16  lines per frame; latched at frame_start.
- addr_in  in  ASIZE  current address from the address generator.
- new_base  out  1  pulse: generator loads the frame base address.
- burst_done  out  1  pulse: generator advances by one full burst.
- tail_done  out  1  pulse: generator moves to the next line start.
- ar_valid  out  1  request valid.
- ar_ready  in  1  request accepted.
- ar_addr  out  ASIZE  request address.
- ar_len  out  LSIZE  beats-1.
- busy  out  1  high from frame accept until frame_done.
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset mid-frame aborts immediately; any pending ar_valid drops the next cycle with no handshake completed.
- All strobes are single-cycle pulses, low for at least ADDR_SETTLE cycles before the next strobe. This guarantees the generator's edge detectors see every pulse.
- States:
  - IDLE: on frame_start with vactive≠0 and (line_bursts≠0 or tail_len≠0), latch config and go to BASE. Otherwise frame_start is ignored. frame_start is also ignored in every other state.
  - BASE: new_base=1 for one cycle; busy=1 from this cycle. Go to SETTLE.
  - SETTLE: count ADDR_SETTLE cycles, then go to REQ.
    - Burst counter < line_bursts: request a full burst, ar_len=BURST_LEN-1.
    - Otherwise, tail_len≠0: request a tail, ar_len=tail_len-1.
    - Otherwise: go to LINE_END (no request).
  - REQ: ar_valid=1, ar_addr=addr_in sampled at REQ entry. ar_addr and ar_len stay stable until the cycle where ar_valid&ar_ready. On that cycle go to STEP.
  - STEP (one cycle):
    - After a full burst: burst_done=1, increment burst counter, go to SETTLE.
    - After a tail: go to LINE_END.
  - LINE_END (one cycle): tail_done=1, clear burst counter, increment line counter.
    - Line counter reaches vactive: go to DONE.
    - Otherwise: go to SETTLE.
  - DONE: frame_done=1 for one cycle, busy=0 the same cycle, go to IDLE.
- Latency:
  - frame_start at cycle T: new_base at T+1; first ar_valid at T+2+ADDR_SETTLE.
  - Handshake at cycle H: burst_done at H+1; next ar_valid at H+2+ADDR_SETTLE.
- tail_done is always pulsed once per line, with or without a tail burst.
- Counters are 16-bit. A line count of 65535 completes without wrap.
- ar_ready while ar_valid=0 is ignored.

Test Plan:
- Reset then frame_start with line_bursts=2, tail_len=0x40, vactive=2, BURST_LEN=256, ar_ready tied 1, and a model generator with base 0x1000, BURST_MAP 0x800, line pitch 0x2000.
  - Required: 6 requests with addr/len 0x1000/255, 0x1800/255, 0x2000/63, 0x3000/255, 0x3800/255, 0x4000/63.
  - Required: 4 burst_done, 2 tail_done, 1 new_base, 1 frame_done.
- tail_len=0, line_bursts=1, vactive=3 -> 3 requests, all len 255. Each is followed by burst_done and then tail_done ADDR_SETTLE+1 cycles later. No tail request is issued.
- ar_ready held low 10 cycles during the first request -> ar_valid stays high, ar_addr/ar_len remain stable all 10 cycles, and burst_done is issued exactly once, one cycle after acceptance.
- frame_start pulsed while busy, and frame_start with vactive=0 -> both ignored; no strobe and no request is emitted.
- Assert rst while ar_valid=1 in line 1 -> next cycle all outputs 0. A later frame_start restarts cleanly with new_base and the first request at the base address.
- line_bursts=0, tail_len=16, vactive=1 -> a single request with len 15, tail_done, then frame_done; burst_done is never pulsed.

Source files
------------

// File: rtl/frame_burst_issuer.sv
// Read-side burst scheduler: walks a frame as lines x (full bursts + optional tail),
// steering the companion address generator and issuing AR requests from its address.
module frame_burst_issuer #(
    parameter int ASIZE       = 29,
    parameter int LSIZE       = 8,
    parameter int BURST_LEN   = 256,
    parameter int ADDR_SETTLE = 3
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             frame_start,
    input  logic [15:0]      line_bursts,
    input  logic [LSIZE:0]   tail_len,
    input  logic [15:0]      vactive,
    input  logic [ASIZE-1:0] addr_in,
    output logic             new_base,
    output logic             burst_done,
    output logic             tail_done,
    output logic             ar_valid,
    input  logic             ar_ready,
    output logic [ASIZE-1:0] ar_addr,
    output logic [LSIZE-1:0] ar_len,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_BASE, S_SETTLE, S_REQ, S_STEP, S_LINE_END, S_DONE
    } state_t;

    localparam int SW = (ADDR_SETTLE > 1) ? $clog2(ADDR_SETTLE) : 1;
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(ADDR_SETTLE - 1);
    localparam logic [LSIZE-1:0] FULL_LEN    = LSIZE'(BURST_LEN - 1);

    state_t          state;
    logic [SW-1:0]   settle_cnt;
    logic [15:0]     burst_cnt;
    logic [15:0]     line_cnt;
    logic [15:0]     lb_q;
    logic [LSIZE:0]  tl_q;
    logic [15:0]     va_q;
    logic            is_tail;

    // AR handshake: ar_valid rises with ar_addr/ar_len already registered, holds them
    // unchanged until a cycle with ar_valid && ar_ready, and is withdrawn only by reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            burst_cnt  <= '0;
            line_cnt   <= '0;
            lb_q       <= '0;
            tl_q       <= '0;
            va_q       <= '0;
            is_tail    <= 1'b0;
            new_base   <= 1'b0;
            burst_done <= 1'b0;
            tail_done  <= 1'b0;
            ar_valid   <= 1'b0;
            ar_addr    <= '0;
            ar_len     <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            new_base   <= 1'b0;
            burst_done <= 1'b0;
            tail_done  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_start && vactive != 16'd0 &&
                        (line_bursts != 16'd0 || tail_len != '0)) begin
                        lb_q      <= line_bursts;
                        tl_q      <= tail_len;
                        va_q      <= vactive;
                        burst_cnt <= '0;
                        line_cnt  <= '0;
                        new_base  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_BASE;
                    end
                end
                S_BASE: begin
                    settle_cnt <= '0;
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    // The generator output is only trusted after the full settle window.
                    if (settle_cnt == SETTLE_LAST) begin
                        if (burst_cnt < lb_q) begin
                            ar_valid <= 1'b1;
                            ar_addr  <= addr_in;
                            ar_len   <= FULL_LEN;
                            is_tail  <= 1'b0;
                            state    <= S_REQ;
                        end else if (tl_q != '0) begin
                            ar_valid <= 1'b1;
                            ar_addr  <= addr_in;
                            ar_len   <= LSIZE'(tl_q - 1'b1);
                            is_tail  <= 1'b1;
                            state    <= S_REQ;
                        end else begin
                            tail_done <= 1'b1;
                            state     <= S_LINE_END;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_REQ: begin
                    if (ar_ready) begin
                        ar_valid   <= 1'b0;
                        burst_done <= !is_tail;
                        state      <= S_STEP;
                    end
                end
                S_STEP: begin
                    if (is_tail) begin
                        tail_done <= 1'b1;
                        state     <= S_LINE_END;
                    end else begin
                        burst_cnt  <= burst_cnt + 16'd1;
                        settle_cnt <= '0;
                        state      <= S_SETTLE;
                    end
                end
                S_LINE_END: begin
                    burst_cnt <= '0;
                    line_cnt  <= line_cnt + 16'd1;
                    if (line_cnt + 16'd1 == va_q) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_DONE;
                    end else begin
                        settle_cnt <= '0;
                        state      <= S_SETTLE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_burst_issuer.sv
// Bench for frame_burst_issuer: model address generator, randomized frames,
// expected requests and strobe timing derived from frame geometry.
module tb_frame_burst_issuer;

    localparam int ASIZE = 29;
    localparam int LSIZE = 8;
    localparam int BURST_LEN = 256;
    localparam int AS = 3;
    localparam int W = ASIZE + LSIZE;
    localparam int BASE = 'h1000;
    localparam int BMAP = 'h800;
    localparam int PITCH = 'h2000;

    logic             clock = 1'b0;
    logic             rst = 1'b1;
    logic             frame_start = 1'b0;
    logic [15:0]      line_bursts = '0;
    logic [LSIZE:0]   tail_len = '0;
    logic [15:0]      vactive = '0;
    logic [ASIZE-1:0] addr_in = '0;
    logic             new_base, burst_done, tail_done, ar_valid, busy, frame_done;
    logic             ar_ready;
    logic [ASIZE-1:0] ar_addr;
    logic [LSIZE-1:0] ar_len;

    frame_burst_issuer #(.ASIZE(ASIZE), .LSIZE(LSIZE), .BURST_LEN(BURST_LEN), .ADDR_SETTLE(AS)) dut (
        .clock(clock), .rst(rst), .frame_start(frame_start), .line_bursts(line_bursts),
        .tail_len(tail_len), .vactive(vactive), .addr_in(addr_in), .new_base(new_base),
        .burst_done(burst_done), .tail_done(tail_done), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .ar_addr(ar_addr), .ar_len(ar_len), .busy(busy), .frame_done(frame_done)
    );

    // clock / reset
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
        $fatal(1);
    end

    // model address generator
    logic [ASIZE-1:0] gen_line = '0;
    always @(posedge clock) begin
        if (new_base) begin
            gen_line <= ASIZE'(BASE);
            addr_in  <= ASIZE'(BASE);
        end else if (burst_done) begin
            addr_in <= addr_in + ASIZE'(BMAP);
        end else if (tail_done) begin
            gen_line <= gen_line + ASIZE'(PITCH);
            addr_in  <= gen_line + ASIZE'(PITCH);
        end
    end

    // ar_ready driver: 0 tied high, 1 random, 2 stall first request 10 cycles, 3 tied low
    int ready_mode = 3;
    int stall_left = 0;
    initial begin
        ar_ready = 1'b0;
        forever begin
            @(posedge clock); #1;
            case (ready_mode)
                0: ar_ready = 1'b1;
                1: ar_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (stall_left > 0) begin
                        ar_ready = 1'b0;
                        if (ar_valid) stall_left--;
                    end else begin
                        ar_ready = 1'b1;
                    end
                end
                default: ar_ready = 1'b0;
            endcase
        end
    end

    // monitor
    logic [W-1:0] hs_q[$];
    int hs_cyc_q[$], av_rise_q[$], nb_q[$], bd_q[$], td_q[$], fd_q[$];
    int drop_err, stab_err, spacing_err, busy_err, last_strobe;
    logic prev_valid = 1'b0, prev_hs = 1'b0;
    logic [W-1:0] prev_req = '0;

    always @(negedge clock) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            int ns;
            if (ar_valid && !prev_valid) av_rise_q.push_back(cyc);
            if (prev_valid && !prev_hs) begin
                if (!ar_valid) drop_err++;
                else if ({ar_addr, ar_len} !== prev_req) stab_err++;
            end
            if (ar_valid && ar_ready) begin
                hs_q.push_back({ar_addr, ar_len});
                hs_cyc_q.push_back(cyc);
            end
            ns = int'(new_base) + int'(burst_done) + int'(tail_done);
            if (ns > 0) begin
                if (ns > 1 || cyc - last_strobe < AS + 1) spacing_err++;
                last_strobe = cyc;
            end
            if (new_base) nb_q.push_back(cyc);
            if (burst_done) bd_q.push_back(cyc);
            if (tail_done) td_q.push_back(cyc);
            if (frame_done) fd_q.push_back(cyc);
            if ((new_base || ar_valid) && !busy) busy_err++;
            if (frame_done && busy) busy_err++;
            prev_valid = ar_valid;
            prev_hs    = ar_valid && ar_ready;
            prev_req   = {ar_addr, ar_len};
        end
    end

    // scoreboard
    int n_checks = 0;
    int n_pass = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_mon();
        hs_q.delete(); hs_cyc_q.delete(); av_rise_q.delete();
        nb_q.delete(); bd_q.delete(); td_q.delete(); fd_q.delete();
        drop_err = 0; stab_err = 0; spacing_err = 0; busy_err = 0;
        last_strobe = -100;
    endtask

    task automatic pulse_start(input int lb, input int tl, input int va);
        line_bursts = 16'(lb);
        tail_len    = 9'(tl);
        vactive     = 16'(va);
        frame_start = 1'b1;
        @(posedge clock); #1;
        frame_start = 1'b0;
    endtask

    task automatic run_frame(input int lb, input int tl, input int va, input int mode, input bit extra);
        bit exp_full[$];
        int exp_line[$];
        int t_start, waited, nf;
        exp_q.delete();
        for (int l = 0; l < va; l++) begin
            for (int b = 0; b < lb; b++) begin
                exp_q.push_back({ASIZE'(BASE + l * PITCH + b * BMAP), LSIZE'(BURST_LEN - 1)});
                exp_full.push_back(1'b1);
                exp_line.push_back(l);
            end
            if (tl != 0) begin
                exp_q.push_back({ASIZE'(BASE + l * PITCH + lb * BMAP), LSIZE'(tl - 1)});
                exp_full.push_back(1'b0);
                exp_line.push_back(l);
            end
        end
        clear_mon();
        ready_mode = mode;
        stall_left = 10;
        @(posedge clock); #1;
        t_start = cyc;
        pulse_start(lb, tl, va);
        if (extra) begin
            repeat (4) @(posedge clock);
            #1;
            pulse_start(5, 3, 4);
        end
        waited = 0;
        while (fd_q.size() == 0 && waited < 5000) begin
            @(posedge clock); #1;
            waited++;
        end
        check("frame_timeout", waited < 5000, 1);
        repeat (3) @(posedge clock);
        #1;

        check("new_base_count", nb_q.size(), 1);
        if (nb_q.size() > 0) check("new_base_latency", nb_q[0], t_start + 1);
        if (av_rise_q.size() > 0) check("first_req_latency", av_rise_q[0], t_start + 2 + AS);
        check("req_count", hs_q.size(), exp_q.size());
        check("valid_rise_count", av_rise_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++)
            check($sformatf("req%0d_addr_len", i), hs_q[i], exp_q[i]);
        check("burst_done_count", bd_q.size(), lb * va);
        check("tail_done_count", td_q.size(), va);
        check("frame_done_count", fd_q.size(), 1);
        nf = 0;
        for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
            if (exp_full[i]) begin
                if (nf < bd_q.size()) check("burst_done_latency", bd_q[nf], hs_cyc_q[i] + 1);
                nf++;
                if (i + 1 < exp_q.size() && exp_line[i + 1] == exp_line[i] && i + 1 < av_rise_q.size())
                    check("next_req_latency", av_rise_q[i + 1], hs_cyc_q[i] + 2 + AS);
            end else if (exp_line[i] < td_q.size()) begin
                check("tail_done_after_tail", td_q[exp_line[i]], hs_cyc_q[i] + 2);
            end
        end
        if (tl == 0 && lb > 0) begin
            for (int l = 0; l < va && l < td_q.size(); l++)
                if (l * lb + lb - 1 < bd_q.size())
                    check("tail_done_no_tail", td_q[l], bd_q[l * lb + lb - 1] + AS + 1);
        end
        if (fd_q.size() > 0 && td_q.size() > 0) check("frame_done_latency", fd_q[0], td_q[td_q.size() - 1] + 1);
        check("valid_dropped", drop_err, 0);
        check("req_unstable", stab_err, 0);
        check("strobe_spacing", spacing_err, 0);
        check("busy_window", busy_err, 0);
        check("idle_after_frame", {busy, ar_valid}, 0);
    endtask

    task automatic ignored_start(input int lb, input int tl, input int va);
        clear_mon();
        ready_mode = 0;
        @(posedge clock); #1;
        pulse_start(lb, tl, va);
        repeat (30) @(posedge clock);
        #1;
        check("ignored_new_base", nb_q.size(), 0);
        check("ignored_requests", av_rise_q.size(), 0);
        check("ignored_busy", busy, 0);
    endtask

    initial begin
        int waited, lb, tl, va;
        clear_mon();
        rst = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", {new_base, burst_done, tail_done, ar_valid, busy, frame_done}, 0);
        check("reset_ar_addr_len", {ar_addr, ar_len}, 0);
        rst = 1'b0;

        run_frame(2, 'h40, 2, 0, 0);
        run_frame(1, 0, 3, 0, 0);
        run_frame(2, 'h40, 2, 2, 0);
        if (hs_cyc_q.size() > 0 && av_rise_q.size() > 0)
            check("stall_10_cycles", hs_cyc_q[0] - av_rise_q[0], 10);
        run_frame(2, 'h40, 2, 1, 1);
        ignored_start(2, 'h40, 0);
        ignored_start(0, 0, 2);

        // reset while the first request of line 1 is pending
        clear_mon();
        ready_mode = 3;
        @(posedge clock); #1;
        pulse_start(2, 'h40, 2);
        waited = 0;
        while (!ar_valid && waited < 100) begin
            @(posedge clock); #1;
            waited++;
        end
        check("rst_wait_valid", ar_valid, 1);
        rst = 1'b1;
        @(posedge clock); #1;
        check("midframe_rst_strobes", {new_base, burst_done, tail_done, frame_done}, 0);
        check("midframe_rst_ar", {ar_valid, ar_addr, ar_len}, 0);
        check("midframe_rst_busy", busy, 0);
        check("midframe_rst_no_hs", hs_q.size(), 0);
        rst = 1'b0;
        run_frame(2, 'h40, 2, 0, 0);

        run_frame(0, 16, 1, 0, 0);

        for (int n = 0; n < 8; n++) begin
            lb = $urandom_range(0, 3);
            tl = ($urandom_range(0, 1) != 0) ? $urandom_range(1, BURST_LEN - 1) : 0;
            va = $urandom_range(1, 3);
            if (lb == 0 && tl == 0) tl = 1;
            run_frame(lb, tl, va, 1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
